// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serializes one command (8-bit ID + 32-bit value) as a HEADER-led 8N1 byte frame.
// Define UART_CMD_TX_CHECKSUM_EN to append an XOR checksum byte (ID and data bytes, HEADER excluded).
module uart_cmd_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_id,
    input  logic [31:0] cmd_data,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int            TW   = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
`ifdef UART_CMD_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd6;
`else
    localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_n;
    logic [2:0]    byte_idx, byte_n;
    logic [7:0]    id_q;
    logic [31:0]   data_q;
    logic [7:0]    cur_byte;
    logic          tick;
    logic          accept;

    assign accept = cmd_valid && cmd_ready;
    assign tick   = (timer == TMAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (accept) begin
                    state_n = START;
                    byte_n  = '0;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (tick) begin
                if (bit_idx == 3'd7) state_n = STOP;
                else                 bit_n   = bit_idx + 3'd1;
            end
            STOP: if (tick) begin
                if (byte_idx == LAST_BYTE) begin
                    state_n = IDLE;
                end else begin
                    state_n = START;
                    byte_n  = byte_idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE) timer_n = tick ? '0 : timer + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q   <= '0;
            data_q <= '0;
        end else if (accept) begin
            id_q   <= cmd_id;
            data_q <= cmd_data;
        end
    end

`ifdef UART_CMD_TX_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = id_q ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
`endif

    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd1: cur_byte = id_q;
            3'd2: cur_byte = data_q[31:24];
            3'd3: cur_byte = data_q[23:16];
            3'd4: cur_byte = data_q[15:8];
            3'd5: cur_byte = data_q[7:0];
`ifdef UART_CMD_TX_CHECKSUM_EN
            3'd6: cur_byte = checksum;
`endif
            default: cur_byte = HEADER;
        endcase
    end

    // Outputs are registered from the current state, so the whole line lags the FSM by one
    // cycle; this gives the accept-to-start-bit cycle and lets frame_done see busy falling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            RS232_Tx   <= 1'b1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cmd_ready  <= (state == IDLE) && !accept;
            busy       <= (state != IDLE);
            frame_done <= busy && (state == IDLE);
            case (state)
                START:   RS232_Tx <= 1'b0;
                DATA:    RS232_Tx <= cur_byte[bit_idx];
                default: RS232_Tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx with CLKS_PER_BIT=4; expected frame sizes follow UART_CMD_TX_CHECKSUM_EN.
module tb_uart_cmd_tx;

    localparam int CPB = 4;
`ifdef UART_CMD_TX_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int LAT = NB * 10 * CPB + 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_id = 8'h00;
    logic [31:0] cmd_data = 32'h0;
    logic        RS232_Tx;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int framing_err = 0;
    int acc_q[$];
    int done_q[$];
    logic done_busy = 1'b0;
    logic done_ready = 1'b0;
    logic [7:0] rx_q[$];
    int rx_cyc_q[$];
    logic line_log [0:8191];

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_data(cmd_data), .RS232_Tx(RS232_Tx), .busy(busy),
        .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    // Edge counter plus handshake log: each accept records the index of the edge that took it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_q.push_back(cyc + 1);
    end

    always @(negedge clk) begin
        if (cyc < 8192) line_log[cyc] <= RS232_Tx;
        if (frame_done === 1'b1) begin
            done_q.push_back(cyc);
            done_busy  <= busy;
            done_ready <= cmd_ready;
        end
    end

    // UART receiver: samples mid-bit, drops any byte overlapped by reset.
    initial begin : uart_mon
        int s;
        logic bad, stop;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && RS232_Tx === 1'b0) begin
                s = cyc; bad = 1'b0; b = '0;
                repeat (2) begin @(negedge clk); if (resetn !== 1'b1) bad = 1'b1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (resetn !== 1'b1) bad = 1'b1; end
                    b[i] = RS232_Tx;
                end
                repeat (CPB) begin @(negedge clk); if (resetn !== 1'b1) bad = 1'b1; end
                stop = RS232_Tx;
                if (!bad) begin
                    rx_q.push_back(b);
                    rx_cyc_q.push_back(s);
                    if (stop !== 1'b1) framing_err++;
                end
            end
        end
    end

    initial begin : watchdog
        #(20 * 60000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_cmd(input logic [7:0] id, input logic [31:0] data, input string name);
        int n0 = acc_q.size();
        int n = 0;
        @(negedge clk); #2;
        cmd_id = id; cmd_data = data; cmd_valid = 1'b1;
        while (acc_q.size() == n0 && n < 50) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b0;
        checks++;
        if (acc_q.size() != n0 + 1) begin
            errors++;
            $display("[TB] FAIL %s accept: accepts %0d required %0d", name, acc_q.size() - n0, 1);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_q.size() < target && n < 1200) begin @(negedge clk); n++; end
        checks++;
        if (done_q.size() < target) begin
            errors++;
            $display("[TB] FAIL %s done_timeout: frame_done count %0d required %0d", name, done_q.size(), target);
        end
    endtask

    task automatic test_reset;
        cmd_valid = 1'b1; cmd_id = 8'h77; cmd_data = 32'h12345678;
        repeat (3) @(negedge clk);
        checks += 4;
        if (RS232_Tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", RS232_Tx); end
        if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", cmd_ready); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", frame_done); end
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks += 3;
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_rise: got %b want 1", cmd_ready); end
        if (acc_q.size() != 0) begin errors++; $display("[TB] FAIL reset_no_accept: accepts %0d want 0", acc_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_after: got %b want 0", busy); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_frame;
        logic [7:0] exp [7];
        logic [7:0] got;
        int d0 = done_q.size();
        exp = '{8'hA5, 8'h12, 8'h00, 8'h00, 8'h01, 8'h04, 8'h17};
        rx_q.delete(); rx_cyc_q.delete();
        send_cmd(8'h12, 32'h0000_0104, "single");
        @(posedge clk); #1;
        checks += 3;
        if (RS232_Tx !== 1'b0) begin errors++; $display("[TB] FAIL single_start_edge: tx %b want 0", RS232_Tx); end
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_edge: busy %b want 1", busy); end
        if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_edge: ready %b want 0", cmd_ready); end
        wait_done(d0 + 1, "single");
        repeat (3) @(negedge clk);
        checks += 6;
        if (done_q.size() != d0 + 1) begin errors++; $display("[TB] FAIL single_done_width: pulses %0d want 1", done_q.size() - d0); end
        if (done_q.size() > d0 && done_q[d0] - acc_q[$] != LAT) begin
            errors++; $display("[TB] FAIL single_latency: got %0d want %0d", done_q[d0] - acc_q[$], LAT);
        end
        if (done_busy !== 1'b0 || done_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL single_done_flags: busy %b ready %b want busy 0 ready 1", done_busy, done_ready);
        end
        if (rx_q.size() != NB) begin errors++; $display("[TB] FAIL single_bytes: got %0d want %0d", rx_q.size(), NB); end
        if (rx_cyc_q.size() == 0 || rx_cyc_q[0] != acc_q[$] + 1) begin
            errors++; $display("[TB] FAIL single_first_start: start edge %0d want %0d", (rx_cyc_q.size() > 0) ? rx_cyc_q[0] : -1, acc_q[$] + 1);
        end
        if (framing_err != 0) begin errors++; $display("[TB] FAIL single_stop_bits: framing errors %0d want 0", framing_err); end
        for (int i = 0; i < NB; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("[TB] FAIL single_byte%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_bit_timing;
        logic [9:0] pat = 10'h2AA;
        int s;
        bit ok;
        int d0 = done_q.size();
        rx_q.delete(); rx_cyc_q.delete();
        send_cmd(8'h55, 32'h0000_0000, "bits");
        wait_done(d0 + 1, "bits");
        checks++;
        if (rx_q.size() < 2 || rx_q[1] !== 8'h55) begin
            errors++; $display("[TB] FAIL bits_byte: got %h want 55", (rx_q.size() > 1) ? rx_q[1] : 8'hxx);
        end
        if (rx_cyc_q.size() >= 2) begin
            s = rx_cyc_q[1];
            for (int j = 0; j < 10; j++) begin
                ok = 1'b1;
                for (int c = 0; c < CPB; c++) if (line_log[s + CPB * j + c] !== pat[j]) ok = 1'b0;
                checks++;
                if (!ok) begin errors++; $display("[TB] FAIL bits_bit%0d: level not held at %b for %0d cycles", j, pat[j], CPB); end
            end
            checks += 2;
            if (line_log[s - 1] !== 1'b1) begin errors++; $display("[TB] FAIL bits_before: got %b want 1", line_log[s - 1]); end
            if (line_log[s + 10 * CPB] !== 1'b0) begin errors++; $display("[TB] FAIL bits_next_start: got %b want 0", line_log[s + 10 * CPB]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [14];
        logic [7:0] got;
        int a0 = acc_q.size();
        int d0 = done_q.size();
        int n = 0;
        exp = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23,
                8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        rx_q.delete(); rx_cyc_q.delete();
        @(negedge clk); #2;
        cmd_id = 8'h01; cmd_data = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        while (acc_q.size() == a0 && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk); #2;
        cmd_id = 8'h02; cmd_data = 32'h0000_0000;
        n = 0;
        while (acc_q.size() < a0 + 2 && n < 600) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b0;
        wait_done(d0 + 2, "b2b");
        repeat (3) @(negedge clk);
        checks += 4;
        if (acc_q.size() != a0 + 2) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d want 2", acc_q.size() - a0); end
        if (acc_q.size() >= a0 + 2 && done_q.size() > d0 && acc_q[a0 + 1] != done_q[d0] + 1) begin
            errors++; $display("[TB] FAIL b2b_accept_edge: got %0d want %0d", acc_q[a0 + 1], done_q[d0] + 1);
        end
        if (rx_q.size() != 2 * NB) begin errors++; $display("[TB] FAIL b2b_bytes: got %0d want %0d", rx_q.size(), 2 * NB); end
        if (rx_cyc_q.size() > NB && done_q.size() > d0 && rx_cyc_q[NB] - done_q[d0] != 2) begin
            errors++; $display("[TB] FAIL b2b_idle: idle cycles after done %0d want 1", rx_cyc_q[NB] - done_q[d0] - 1);
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB; i++) begin
                got = (f * NB + i < rx_q.size()) ? rx_q[f * NB + i] : 8'hxx;
                checks++;
                if (got !== exp[f * 7 + i]) begin
                    errors++; $display("[TB] FAIL b2b_f%0d_byte%0d: got %h want %h", f, i, got, exp[f * 7 + i]);
                end
            end
        end
    endtask

    task automatic test_input_change;
        logic [7:0] exp [7];
        logic [7:0] got;
        int a0 = acc_q.size();
        int d0 = done_q.size();
        int n = 0;
        exp = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h78};
        rx_q.delete(); rx_cyc_q.delete();
        @(negedge clk); #2;
        cmd_id = 8'h3C; cmd_data = 32'h1122_3344; cmd_valid = 1'b1;
        while (acc_q.size() == a0 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        cmd_data = 32'hFFFF_FFFF; cmd_id = 8'hFF;
        repeat (150) @(negedge clk);
        #2 cmd_valid = 1'b0;
        wait_done(d0 + 1, "change");
        checks++;
        if (acc_q.size() != a0 + 1) begin errors++; $display("[TB] FAIL change_accepts: got %0d want 1", acc_q.size() - a0); end
        for (int i = 0; i < NB; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("[TB] FAIL change_byte%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp [7];
        logic [7:0] got;
        int a, d0;
        exp = '{8'hA5, 8'hA0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h5F};
        send_cmd(8'h12, 32'h0000_0104, "midreset");
        a = acc_q[$];
        d0 = done_q.size();
        while (cyc < a + 95) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks += 2;
        if (RS232_Tx !== 1'b1) begin errors++; $display("[TB] FAIL midreset_tx: got %b want 1", RS232_Tx); end
        if (busy !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_flags: busy %b ready %b want 0 0", busy, cmd_ready);
        end
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b want 1", cmd_ready); end
        repeat (200) @(negedge clk);
        checks++;
        if (done_q.size() != d0) begin errors++; $display("[TB] FAIL midreset_no_done: pulses %0d want 0", done_q.size() - d0); end
        rx_q.delete(); rx_cyc_q.delete();
        send_cmd(8'hA0, 32'h0000_00FF, "postreset");
        wait_done(d0 + 1, "postreset");
        checks++;
        if (done_q.size() > d0 && done_q[d0] - acc_q[$] != LAT) begin
            errors++; $display("[TB] FAIL postreset_latency: got %0d want %0d", done_q[d0] - acc_q[$], LAT);
        end
        for (int i = 0; i < NB; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("[TB] FAIL postreset_byte%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_timing();
        test_back_to_back();
        test_input_change();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
